// File: rtl/alu_pkg.sv
// Shared opcode/state types and decode helpers for the
// sequential ALU and its iterative multiply/divide unit.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_AND  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_NOR  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_DIVU = 4'b1010,
    OP_REMU = 4'b1011,
    OP_SRL  = 4'b1100,
    OP_SLL  = 4'b1101,
    OP_SRA  = 4'b1110
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic logic is_multicycle(
    input logic [3:0] op
  );
    return (op == OP_MUL)
        || (op == OP_DIVU)
        || (op == OP_REMU);
  endfunction

  function automatic logic is_legal(
    input logic [3:0] op
  );
    return !((op == 4'b1001)
          || (op == 4'b1111));
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring
// divide, one bit per cycle over WIDTH cycles.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  logic             busy;
  logic             is_mul;
  logic             is_rem;
  logic [CNT_W-1:0] cnt;
  // acc: product or partial remainder;
  // opa: multiplier or dividend/quotient;
  // opb: multiplicand or divisor
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;

  always_comb begin
    mul_acc = acc + (opa[0] ? opb : '0);
    rem_sh  = {acc, opa[WIDTH-1]};
    trial   = rem_sh - {1'b0, opb};
    qbit    = ~trial[WIDTH];
    rem_n   = qbit ? trial[WIDTH-1:0]
                   : rem_sh[WIDTH-1:0];
    quo_n   = {opa[WIDTH-2:0], qbit};
  end

  // Result reflects the step being taken this cycle,
  // so it is final in the same cycle done is high.
  assign done   = busy && (cnt == LAST);
  assign result = is_mul ? mul_acc
                : is_rem ? rem_n
                : quo_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      is_mul <= 1'b0;
      is_rem <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      is_mul <= (op == OP_MUL);
      is_rem <= (op == OP_REMU);
      cnt    <= '0;
      acc    <= '0;
      if (op == OP_MUL) begin
        opa <= b;
        opb <= a;
      end else begin
        opa <= a;
        opb <= b;
      end
    end else if (busy) begin
      cnt  <= cnt + 1'b1;
      busy <= !done;
      if (is_mul) begin
        acc <= mul_acc;
        opa <= opa >> 1;
        opb <= opb << 1;
      end else begin
        acc <= rem_n;
        opa <= quo_n;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops and flags here, with
// MUL/DIVU/REMU delegated to the iterative unit.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_n;
  logic             zero_q;
  logic             zero_n;
  logic             ovf_q;
  logic             ovf_n;
  logic             ill_q;
  logic             ill_n;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   dif;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ovf;
  logic               slt;
  logic               sltu;

  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;

  assign md_start = (state == IDLE) && in_valid
                 && is_legal(alu_op)
                 && is_multicycle(alu_op);

  alu_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (alu_op),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    sum    = a + b;
    dif    = a - b;
    shamt  = b[SHAMT_W-1:0];
    slt    = $signed(a) < $signed(b);
    sltu   = a < b;
    sc_res = '0;
    sc_ovf = 1'b0;
    case (alu_op)
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1])
              && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1])
              && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, sltu};
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_SRL:  sc_res = a >> shamt;
      OP_SLL:  sc_res = a << shamt;
      OP_SRA:  sc_res = $unsigned($signed(a) >>> shamt);
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    res_n   = res_q;
    zero_n  = zero_q;
    ovf_n   = ovf_q;
    ill_n   = ill_q;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (!is_legal(alu_op)) begin
            state_n = DONE;
            res_n   = '0;
            zero_n  = 1'b1;
            ovf_n   = 1'b0;
            ill_n   = 1'b1;
          end else if (is_multicycle(alu_op)) begin
            state_n = CALC;
          end else begin
            state_n = DONE;
            res_n   = sc_res;
            zero_n  = (sc_res == '0);
            ovf_n   = sc_ovf;
            ill_n   = 1'b0;
          end
        end
      end
      CALC: begin
        if (md_done) begin
          state_n = DONE;
          res_n   = md_result;
          zero_n  = (md_result == '0);
          ovf_n   = 1'b0;
          ill_n   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      res_q  <= '0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      state  <= state_n;
      res_q  <= res_n;
      zero_q <= zero_n;
      ovf_q  <= ovf_n;
      ill_q  <= ill_n;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases
// followed by random operations against an arithmetic model.
module tb_alu_seq;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   alu_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         illegal;

  always #5 clk = ~clk;

  alu_seq #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         ov;
    logic         ill;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   seen = 1'b0;
  int   hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string        nm,
    input logic [W-1:0] act,
    input logic [W-1:0] req
  );
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, req);
    end
  endtask

  function automatic exp_t model(
    input logic [3:0]   op,
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    exp_t e;
    longint sx;
    longint sy;
    longint s;
    longint unsigned p;
    int sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y[4:0]);
    e.res = '0;
    e.ov  = 1'b0;
    e.ill = 1'b0;
    e.lat = 1;
    e.acc = 0;
    case (op)
      4'd0: begin
        s = sx + sy;
        e.res = x + y;
        e.ov = (s > SMAX) || (s < SMIN);
      end
      4'd1: begin
        s = sx - sy;
        e.res = x - y;
        e.ov = (s > SMAX) || (s < SMIN);
      end
      4'd2:  e.res = (sx < sy) ? 1 : 0;
      4'd3:  e.res = (x < y) ? 1 : 0;
      4'd4:  e.res = x & y;
      4'd5:  e.res = x | y;
      4'd6:  e.res = x ^ y;
      4'd7:  e.res = ~(x | y);
      4'd8: begin
        p = longint'(x) * longint'(y);
        e.res = p[31:0];
        e.lat = W + 1;
      end
      4'd10: begin
        e.res = (y == 0) ? '1 : x / y;
        e.lat = W + 1;
      end
      4'd11: begin
        e.res = (y == 0) ? x : x % y;
        e.lat = W + 1;
      end
      4'd12: e.res = x >> sh;
      4'd13: e.res = x << sh;
      4'd14: e.res = (x >> sh)
                   | (x[W-1] ? ~({W{1'b1}} >> sh) : '0);
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Monitor: compares every DONE cycle, drives out_ready
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: valid=1 expected 0");
      end else begin
        if (!seen) begin
          chk("latency", 32'(cyc - sb[0].acc),
              32'(sb[0].lat));
          seen = 1'b1;
        end
        chk("result", result, sb[0].res);
        chk("zero", 32'(zero), 32'(sb[0].z));
        chk("overflow", 32'(overflow), 32'(sb[0].ov));
        chk("illegal", 32'(illegal), 32'(sb[0].ill));
        chk("in_ready_done", 32'(in_ready), 32'd0);
      end
    end
    if (hold > 0 && out_valid) begin
      out_ready = 1'b0;
      hold--;
    end else begin
      out_ready = ($urandom_range(0, 3) != 0);
    end
    if (rst_n && out_valid && out_ready
        && sb.size() > 0) begin
      void'(sb.pop_front());
      seen = 1'b0;
    end
  end

  task automatic send(
    input logic [3:0]   op,
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      return;
    end
    in_valid = 1'b1;
    alu_op = op;
    a = x;
    b = y;
    e = model(op, x, y);
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    alu_op = 4'($urandom);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_zero"}, 32'(zero), 32'd1);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int n;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    send(4'd0, 32'h7FFF_FFFF, 32'd1);
    send(4'd1, 32'h8000_0000, 32'd1);
    send(4'd2, 32'hFFFF_FFFF, 32'd1);
    send(4'd3, 32'hFFFF_FFFF, 32'd1);
    send(4'd14, 32'h8000_0000, 32'd4);
    send(4'd13, 32'hDEAD_BEEF, 32'd0);
    send(4'd12, 32'hDEAD_BEEF, 32'h0000_0020);
    hold = 5;
    send(4'd8, 32'd12345, 32'd6789);
    send(4'd10, 32'd100, 32'd7);
    send(4'd11, 32'd100, 32'd7);
    send(4'd10, 32'hCAFE_F00D, 32'd0);
    send(4'd11, 32'h0000_1234, 32'd0);
    send(4'd9, 32'h1111_1111, 32'h2222_2222);
    send(4'd15, 32'h0, 32'h0);
    send(4'd10, 32'h0000_0005, 32'h0000_0009);

    // Abort a divide partway through with reset
    send(4'd10, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("midcalc");
    send(4'd0, 32'd2, 32'd3);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: begin
          x = $urandom;
          y = $urandom;
        end
        1: begin
          x = 32'($urandom_range(0, 300));
          y = 32'($urandom_range(0, 40));
        end
        2: begin
          x = $urandom;
          y = '0;
        end
        default: begin
          x = $urandom_range(0, 1) != 0
            ? 32'h8000_0000 : 32'h7FFF_FFFF;
          y = $urandom_range(0, 1) != 0
            ? 32'hFFFF_FFFF : 32'h8000_0000;
        end
      endcase
      send(op, x, y);
    end

    n = 0;
    while (sb.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending %0d expected 0",
               sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
